// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - byte-loaded word program store with combinational PC read
module instruction_memory #(
  parameter int WORD_SIZE         = 32,
  parameter int MEM_SIZE_IN_WORDS = 64,
  parameter int PC_SIZE           = 32,
  localparam int BPW              = WORD_SIZE / 8,
  localparam int TOTAL_BYTES      = MEM_SIZE_IN_WORDS * BPW,
  localparam int CNT_W            = $clog2(TOTAL_BYTES) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_inst_write,
  input  logic [7:0]           i_data,
  input  logic [PC_SIZE-1:0]   i_pc,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CNT_W-1:0]     o_byte_count
);

  localparam int IDX_W = $clog2(MEM_SIZE_IN_WORDS);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE_IN_WORDS];
  logic [CNT_W-1:0]     byte_ptr;
  logic [IDX_W-1:0]     wr_word;
  logic [CNT_W-1:0]     wr_lane;
  logic [PC_SIZE-3:0]   rd_idx;
  logic                 pc_offset_unused;

  assign wr_word = IDX_W'(byte_ptr / CNT_W'(BPW));
  assign wr_lane = byte_ptr % CNT_W'(BPW);

  assign o_byte_count = byte_ptr;
  assign o_empty      = (byte_ptr == '0);
  assign o_full       = (byte_ptr == CNT_W'(TOTAL_BYTES));

  // Big-endian fill: position 0 within a word lands in the top byte lane.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      byte_ptr <= '0;
      for (int w = 0; w < MEM_SIZE_IN_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else if (i_inst_write && !o_full) begin
      for (int b = 0; b < BPW; b++) begin
        if (wr_lane == CNT_W'(BPW - 1 - b)) begin
          mem[wr_word][b*8 +: 8] <= i_data;
        end
      end
      byte_ptr <= byte_ptr + CNT_W'(1);
    end
  end

  // PC low bits select a byte within the word and do not affect the fetch.
  assign rd_idx           = i_pc[PC_SIZE-1:2];
  assign pc_offset_unused = ^i_pc[1:0];

  always_comb begin
    o_instruction = '0;
    if (rd_idx < (PC_SIZE-2)'(MEM_SIZE_IN_WORDS)) begin
      o_instruction = mem[rd_idx[IDX_W-1:0]];
    end
  end

endmodule
